byte_mem_ctrl: RTL and testbench
================================

// Module: byte_mem_ctrl
// PURPOSE
//  Parametrised single-port data memory with byte/half/word access, sign/zero-extended loads,
//  req/ack handshake and a multi-cycle hardware clear engine. Next-generation data memory for
//  the CPU load/store path: byte-addressed, with alignment checking and a busy indication
//  while clearing.
// PARAMETERS
//  ADDR_BITS     10  word-address width; DEPTH = 2**ADDR_BITS words
//  DATA_BITS     32  word width; multiple of 8, 32 or 64; LANES = DATA_BITS/8
//  CLR_ON_RESET  1   1: enter CLEAR after reset release; 0: enter IDLE
// PORTS
//  clk       in   1                    clock, all state on rising edge
//  rst_n     in   1                    asynchronous, active-low reset
//  req       in   1                    access request, sampled when busy=0
//  we        in   1                    1 store, 0 load (qualified by req)
//  addr      in   ADDR_BITS+OFF        byte address; OFF = log2(LANES)
//  size      in   2                    log2(bytes): 0 byte, 1 half, 2 word, 3 dword (64-bit only)
//  sign_ext  in   1                    loads: 1 sign-extend, 0 zero-extend
//  data_in   in   DATA_BITS            store data, right-justified
//  clr       in   1                    start full-memory clear (pulse)
//  data_out  out  DATA_BITS            load result, right-justified, extended
//  ack       out  1                    one-cycle completion pulse
//  err       out  1                    valid with ack: misaligned or illegal size
//  busy      out  1                    1 while clearing; requests not accepted
// BEHAVIOUR
//  - Reset (rst_n=0, async): data_out=0, ack=0, err=0, clr counter=0; state=CLEAR if
//    CLR_ON_RESET else IDLE; busy=1 in CLEAR. The array is not reset; contents undefined until cleared.
//  - FSM: IDLE -> CLEAR on clr=1; CLEAR -> IDLE after the cycle writing word DEPTH-1.
//    CLEAR writes zero to word cnt each cycle, cnt 0..DEPTH-1, i.e. exactly DEPTH cycles.
//  - Access accepted on edge where state=IDLE, req=1, clr=0. ack pulses the next cycle
//    (latency 1). Back-to-back requests: one per cycle, no bubbles.
//  - Illegal: size>log2(LANES), or addr[OFF-1:0] not multiple of 2**size. Response: ack=1,
//    err=1, no array write, data_out unchanged.
//  - Store: lane = addr[OFF-1:0]; the low 2**size bytes of data_in are written at that byte
//    offset. Other bytes of the word are untouched. data_out holds its previous value.
//    ack=1, err=0.
//  - Load: the selected bytes are shifted to bit 0, then extended to DATA_BITS per
//    sign_ext (MSB of the selected field). A full-width load ignores sign_ext.
//  - Lane numbering: little-endian; byte k = data[8k+7:8k].
//  - Read-after-write: a load accepted the cycle after a store to the same word returns the
//    new data. No same-cycle forwarding is needed (single port, one access per cycle).
//  - clr while busy is ignored (clear continues). clr together with req in IDLE: clr wins,
//    req dropped, no ack.
//  - A req arriving while busy=1 is dropped silently. The requester must hold req until busy=0.
//  - rst_n asserted mid-clear or mid-access: aborts immediately, pending ack lost, counter
//    restarts at 0 (if CLR_ON_RESET).
//  - ack/err are never asserted in CLEAR, except the ack for an access accepted on the
//    clr-starting edge (none, clr wins).
// STRUCTURE
//  - mem_pkg: size encodings (SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3), state enum {IDLE, CLEAR},
//    function is_aligned(addr_lo,size).
//  - Sub-module mem_lane_steer (combinational): store byte-enable + data replication, and load
//    extract/extend. Parametrised by DATA_BITS, reused by the cache path.
//  - Top: FSM, clear counter, array (inferred sync-write/sync-read RAM), response registers.
// TESTING
//  1 Reset, CLR_ON_RESET=1, DEPTH=1024 -> busy=1 for exactly 1024 cycles after rst_n
//    release, then all words read 0.
//  2 sw 0x80FF7F01 @0x10; lb @0x10/0x11/0x12/0x13 sign_ext=1 -> 0x00000001,
//    0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lbu @0x13 -> 0x00000080.
//  3 sh 0xBEEF @0x22 over word 0x11223344 @0x20 -> lw @0x20 = 0xBEEF3344;
//    lh @0x22 -> 0xFFFFBEEF.
//  4 lw @0x21, sh @0x23, size=3 with DATA_BITS=32 -> ack=1, err=1 each; memory unchanged.
//  5 clr and req together, then req during busy -> no ack until clear done; a held req
//    gets ack 1 cycle after busy falls.
//  6 rst_n pulsed at clear cycle 500 -> busy restarts, lasts full DEPTH cycles; data_out=0, ack=0.

Source files
------------

// File: rtl/byte_mem_ctrl_pkg.sv
// Shared definitions for the byte-addressed data memory: access sizes, controller
// states and the alignment rule.
package byte_mem_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // An access of 2**size bytes must start on a multiple of its own size.
  function automatic logic is_aligned(input logic [2:0] addr_lo, input logic [1:0] size);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lo[0] == 1'b0);
      SZ_W:    ok = (addr_lo[1:0] == 2'b00);
      SZ_D:    ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_mem_ctrl_if.sv
// Request/response bundle between a load/store unit and the data memory.
interface byte_mem_ctrl_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32
);
  localparam int OFF = $clog2(DATA_BITS / 8);

  logic                     req;
  logic                     we;
  logic [ADDR_BITS+OFF-1:0] addr;
  logic [1:0]               size;
  logic                     sign_ext;
  logic [DATA_BITS-1:0]     data_in;
  logic                     clr;
  logic [DATA_BITS-1:0]     data_out;
  logic                     ack;
  logic                     err;
  logic                     busy;

  modport master (
    output req, we, addr, size, sign_ext, data_in, clr,
    input  data_out, ack, err, busy
  );

  modport slave (
    input  req, we, addr, size, sign_ext, data_in, clr,
    output data_out, ack, err, busy
  );
endinterface

// File: rtl/byte_mem_ctrl_lane_steer.sv
// Combinational byte-lane steering: store byte enables and data placement, and
// load extraction with sign/zero extension. Illegal sizes are masked by the caller.
module byte_mem_ctrl_lane_steer #(
  parameter  int DATA_BITS = 32,
  localparam int LANES     = DATA_BITS / 8,
  localparam int OFF       = $clog2(LANES)
) (
  input  logic [OFF-1:0]       lane,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic [DATA_BITS-1:0] rword,
  output logic [LANES-1:0]     be,
  output logic [DATA_BITS-1:0] wdata_rep,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] shifted_s;
  logic                 msb_s;
  int                   lo_s;
  int                   nbytes_s;
  int                   nbits_s;

  // Lane placement for stores, right-justification and extension for loads
  always_comb begin
    lo_s      = int'(lane);
    nbytes_s  = ((32'd1 << size) > 32'(LANES)) ? LANES : int'(32'd1 << size);
    nbits_s   = 8 * nbytes_s;
    shifted_s = rword >> {lane, 3'b000};
    wdata_rep = wdata << {lane, 3'b000};
    be        = '0;
    for (int k = 0; k < LANES; k++) begin
      be[k] = (k >= lo_s) && (k < lo_s + nbytes_s);
    end
    msb_s = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (i == nbits_s - 1) begin
        msb_s = shifted_s[i];
      end else begin
        msb_s = msb_s;
      end
    end
    rdata = '0;
    for (int i = 0; i < DATA_BITS; i++) begin
      rdata[i] = (i < nbits_s) ? shifted_s[i] : (sign_ext & msb_s);
    end
  end

endmodule

// File: rtl/byte_mem_ctrl.sv
// Single-port byte-addressed data memory with req/ack handshake, alignment
// checking and a one-word-per-cycle hardware clear engine.
module byte_mem_ctrl
  import byte_mem_ctrl_pkg::*;
#(
  parameter int ADDR_BITS    = 10,
  parameter int DATA_BITS    = 32,
  parameter int CLR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  byte_mem_ctrl_if.slave  bus
);

  localparam int         LANES  = DATA_BITS / 8;
  localparam int         OFF    = $clog2(LANES);
  localparam int         DEPTH  = 2 ** ADDR_BITS;
  localparam logic [1:0] OFF_SZ = 2'(OFF);
  localparam state_t     RST_STATE = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

  logic [DATA_BITS-1:0] mem_r [DEPTH];

  state_t               state_r;
  state_t               state_nxt_s;
  logic [ADDR_BITS-1:0] cnt_r;
  logic [ADDR_BITS-1:0] cnt_nxt_s;
  logic                 ack_r;
  logic                 err_r;
  logic [DATA_BITS-1:0] dout_r;

  logic                 acc_s;
  logic                 illegal_s;
  logic                 st_wr_s;
  logic                 ld_s;
  logic                 clr_wr_s;
  logic [ADDR_BITS-1:0] word_s;
  logic [OFF-1:0]       lane_s;
  logic [DATA_BITS-1:0] rword_s;
  logic [LANES-1:0]     be_s;
  logic [DATA_BITS-1:0] wrep_s;
  logic [DATA_BITS-1:0] ld_data_s;

  assign word_s    = bus.addr[ADDR_BITS+OFF-1:OFF];
  assign lane_s    = bus.addr[OFF-1:0];
  assign illegal_s = (bus.size > OFF_SZ) || !is_aligned(3'(lane_s), bus.size);
  assign rword_s   = mem_r[word_s];

  byte_mem_ctrl_lane_steer #(.DATA_BITS(DATA_BITS)) u_steer (
    .lane      (lane_s),
    .size      (bus.size),
    .sign_ext  (bus.sign_ext),
    .wdata     (bus.data_in),
    .rword     (rword_s),
    .be        (be_s),
    .wdata_rep (wrep_s),
    .rdata     (ld_data_s)
  );

  // Next state, clear counter and access qualification; clr beats a same-cycle req
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    acc_s       = 1'b0;
    clr_wr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (bus.clr) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
          acc_s       = bus.req;
        end
      end
      ST_CLEAR: begin
        clr_wr_s  = 1'b1;
        cnt_nxt_s = cnt_r + 1'b1;
        if (cnt_r == {ADDR_BITS{1'b1}}) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
    st_wr_s = acc_s && !illegal_s && bus.we;
    ld_s    = acc_s && !illegal_s && !bus.we;
  end

  // Control state and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      cnt_r   <= '0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      dout_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ack_r   <= acc_s;
      err_r   <= acc_s && illegal_s;
      if (ld_s) begin
        dout_r <= ld_data_s;
      end
    end
  end

  // Array write port, shared by the clear engine and byte-enabled stores
  always_ff @(posedge clk) begin
    if (clr_wr_s) begin
      mem_r[cnt_r] <= '0;
    end else if (st_wr_s) begin
      for (int k = 0; k < LANES; k++) begin
        if (be_s[k]) begin
          mem_r[word_s][8*k +: 8] <= wrep_s[8*k +: 8];
        end
      end
    end
  end

  assign bus.data_out = dout_r;
  assign bus.ack      = ack_r;
  assign bus.err      = err_r;
  assign bus.busy     = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_byte_mem_ctrl.sv
// Self-checking bench: byte-array reference model compared every cycle, plus
// directed literal checks and a randomized phase.
module tb_byte_mem_ctrl;

  localparam int AB     = 10;
  localparam int DB     = 32;
  localparam int DEPTH  = 1024;
  localparam int NBYTES = 4096;

  logic clk;
  logic rst_n;

  byte_mem_ctrl_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  byte_mem_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .CLR_ON_RESET(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0]  m_mem [NBYTES];
  int          clr_left;
  logic        exp_ack;
  logic        exp_err;
  logic [31:0] exp_dout;
  int          n_checks = 0;
  int          n_errs   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs held across it
  task automatic model_step();
    int nb;
    int a;
    logic [63:0] v;
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (!rst_n) return;
    if (clr_left > 0) begin
      clr_left--;
    end else if (bus.clr) begin
      clr_left = DEPTH;
      for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    end else if (bus.req) begin
      exp_ack = 1'b1;
      nb = 1 << bus.size;
      a  = int'(bus.addr);
      if (nb > 4 || (a % nb) != 0) begin
        exp_err = 1'b1;
      end else if (bus.we) begin
        for (int b = 0; b < nb; b++) m_mem[a + b] = bus.data_in[8*b +: 8];
      end else begin
        v = 64'd0;
        for (int b = 0; b < nb; b++) v = v | (64'(m_mem[a + b]) << (8 * b));
        if (nb < 4 && bus.sign_ext && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 64'd1);
        exp_dout = v[31:0];
      end
    end
  endtask

  always @(negedge clk) begin
    chk("busy", 64'(bus.busy), 64'(clr_left > 0));
    chk("ack", 64'(bus.ack), 64'(exp_ack));
    chk("err", 64'(bus.err), 64'(exp_err));
    chk("data_out", 64'(bus.data_out), 64'(exp_dout));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    rst_n    = 1'b0;
    clr_left = DEPTH;
    exp_ack  = 1'b0;
    exp_err  = 1'b0;
    exp_dout = 32'h0;
    for (int i = 0; i < NBYTES; i++) m_mem[i] = 8'h00;
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  task automatic acc(input logic w, input logic [11:0] a, input logic [1:0] s,
                     input logic se, input logic [31:0] d);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.size = s;
    bus.sign_ext = se; bus.data_in = d;
    tick();
    bus.req = 1'b0;
  endtask

  task automatic measure_busy(input string name);
    int cnt;
    cnt = 0;
    while (bus.busy && cnt < 2000) begin
      tick();
      cnt++;
    end
    chk(name, 64'(cnt), 64'd1024);
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.size = 2'd0;
    bus.sign_ext = 1'b0; bus.data_in = '0; bus.clr = 1'b0;

    // 1: reset clears the whole array
    apply_reset(3);
    chk("reset_dout", 64'(bus.data_out), 64'h0);
    chk("reset_ack", 64'(bus.ack), 64'h0);
    measure_busy("busy_len_reset");
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2;
    for (int w = 0; w < DEPTH; w++) begin
      bus.addr = 12'(w * 4);
      tick();
    end
    bus.req = 1'b0;
    chk("lw_last_cleared", 64'(bus.data_out), 64'h0);

    // 2: byte loads, sign and zero extension
    acc(1'b1, 12'h010, 2'd2, 1'b0, 32'h80FF7F01);
    chk("sw_ack", 64'(bus.ack), 64'h1);
    chk("sw_err", 64'(bus.err), 64'h0);
    acc(1'b0, 12'h010, 2'd0, 1'b1, 32'h0); chk("lb_10", 64'(bus.data_out), 64'h00000001);
    acc(1'b0, 12'h011, 2'd0, 1'b1, 32'h0); chk("lb_11", 64'(bus.data_out), 64'h0000007F);
    acc(1'b0, 12'h012, 2'd0, 1'b1, 32'h0); chk("lb_12", 64'(bus.data_out), 64'hFFFFFFFF);
    acc(1'b0, 12'h013, 2'd0, 1'b1, 32'h0); chk("lb_13", 64'(bus.data_out), 64'hFFFFFF80);
    acc(1'b0, 12'h013, 2'd0, 1'b0, 32'h0); chk("lbu_13", 64'(bus.data_out), 64'h00000080);

    // 3: half store merges into an existing word
    acc(1'b1, 12'h020, 2'd2, 1'b0, 32'h11223344);
    acc(1'b1, 12'h022, 2'd1, 1'b0, 32'h0000BEEF);
    acc(1'b0, 12'h020, 2'd2, 1'b0, 32'h0); chk("lw_20", 64'(bus.data_out), 64'hBEEF3344);
    acc(1'b0, 12'h022, 2'd1, 1'b1, 32'h0); chk("lh_22", 64'(bus.data_out), 64'hFFFFBEEF);

    // 4: misaligned and oversize accesses
    acc(1'b0, 12'h021, 2'd2, 1'b0, 32'h0);
    chk("mis_lw_err", 64'(bus.err), 64'h1);
    chk("mis_lw_dout", 64'(bus.data_out), 64'hFFFFBEEF);
    acc(1'b1, 12'h023, 2'd1, 1'b0, 32'h00001234);
    chk("mis_sh_err", 64'(bus.err), 64'h1);
    acc(1'b1, 12'h020, 2'd3, 1'b0, 32'hDEADBEEF);
    chk("size3_err", 64'(bus.err), 64'h1);
    chk("size3_ack", 64'(bus.ack), 64'h1);
    acc(1'b0, 12'h020, 2'd2, 1'b0, 32'h0); chk("lw_20_kept", 64'(bus.data_out), 64'hBEEF3344);

    // 5: clr wins over req; held req served right after the clear
    begin
      int cnt;
      bus.clr = 1'b1; bus.req = 1'b1; bus.we = 1'b0; bus.addr = 12'h020; bus.size = 2'd2;
      tick();
      bus.clr = 1'b0;
      cnt = 1;
      while (!bus.ack && cnt < 3000) begin
        tick();
        cnt++;
      end
      bus.req = 1'b0;
      chk("ack_after_clr", 64'(cnt), 64'd1026);
      chk("ld_after_clr", 64'(bus.data_out), 64'h0);
    end

    // 6: reset in the middle of a clear restarts it
    acc(1'b1, 12'h040, 2'd2, 1'b0, 32'hCAFEF00D);
    acc(1'b0, 12'h040, 2'd2, 1'b0, 32'h0);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    repeat (500) tick();
    chk("dout_held_in_clear", 64'(bus.data_out), 64'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_dout", 64'(bus.data_out), 64'h0);
    chk("midclr_rst_busy", 64'(bus.busy), 64'h1);
    apply_reset(2);
    measure_busy("busy_len_rerun");

    // Randomized traffic in a small window so stores and loads collide often
    for (int n = 0; n < 4000; n++) begin
      bus.req      = ($urandom % 4) != 0;
      bus.we       = $urandom % 2;
      bus.addr     = 12'($urandom_range(0, 63));
      bus.size     = 2'($urandom % 4);
      bus.sign_ext = $urandom % 2;
      bus.data_in  = $urandom;
      bus.clr      = ($urandom % 1500) == 0;
      tick();
    end
    bus.req = 1'b0;
    bus.clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
